// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches from a 1-cycle-latency
// instruction SRAM and hands {inst, pc} to decode.
//
// Handshake: fs_to_ds_valid/ds_allowin form a valid/allowin pair. The
// instruction on if_id_bus_out is consumed by decode on a posedge where both
// fs_to_ds_valid and ds_allowin are 1. While fs_to_ds_valid=1 and ds_allowin=0
// the bus holds steady (the stall buffer keeps the SRAM word alive).
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ds_allowin,
    output logic        fs_to_ds_valid,
    output logic [63:0] if_id_bus_out,
    input  logic        br_jmp_flag,
    input  logic [31:0] br_target,
    input  logic        trap_flag,
    input  logic [31:0] trap_target,
    output logic        inst_sram_en,
    output logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_rdata
);

    logic        pf_valid;
    logic        fs_valid;
    logic [31:0] fs_pc;
    logic        buf_valid;
    logic [31:0] inst_buf;

    logic        redirect;
    logic        fs_ready_go;
    logic        fs_allowin;
    logic        capture;
    logic [31:0] nextpc;
    logic [31:0] inst;

    assign redirect    = trap_flag | br_jmp_flag;
    assign fs_ready_go = 1'b1;
    assign fs_allowin  = !fs_valid || ds_allowin || redirect;

    // Stall begins: the SRAM word is only on rdata this cycle, so keep it.
    assign capture = fs_valid && !ds_allowin && !buf_valid && !redirect;

    // Next PC: trap beats branch, otherwise sequential (32-bit wrap).
    always_comb begin
        nextpc = fs_pc + 32'd4;
        if (trap_flag) begin
            nextpc = trap_target;
        end else if (br_jmp_flag) begin
            nextpc = br_target;
        end
    end

    assign inst_sram_en   = pf_valid && fs_allowin;
    assign inst_sram_addr = {nextpc[31:2], 2'b00};

    assign inst           = buf_valid ? inst_buf : inst_sram_rdata;
    assign fs_to_ds_valid = fs_valid && fs_ready_go && !redirect;
    assign if_id_bus_out  = fs_to_ds_valid ? {inst, fs_pc} : 64'd0;

    // Pre-fetch gate: fetching starts one cycle after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pf_valid <= 1'b0;
        end else begin
            pf_valid <= 1'b1;
        end
    end

    // PC register and fetch-stage valid advance on every issued fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fs_valid <= 1'b0;
            fs_pc    <= RESET_PC - 32'd4;
        end else if (inst_sram_en) begin
            fs_valid <= 1'b1;
            fs_pc    <= nextpc;
        end
    end

    // One-entry stall buffer; any new fetch (accept or redirect) empties it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid <= 1'b0;
            inst_buf  <= 32'd0;
        end else if (inst_sram_en) begin
            buf_valid <= 1'b0;
        end else if (capture) begin
            buf_valid <= 1'b1;
            inst_buf  <= inst_sram_rdata;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: SRAM model with 1-cycle latency (garbage on cycles
// with no issued fetch), directed phase with literal expectations, then a
// randomized phase checked every cycle against a behavioural model.
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        ds_allowin;
    logic        fs_to_ds_valid;
    logic [63:0] if_id_bus_out;
    logic        br_jmp_flag;
    logic [31:0] br_target;
    logic        trap_flag;
    logic [31:0] trap_target;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata;

    int n_vec;
    int n_err;

    if_stage #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ds_allowin     (ds_allowin),
        .fs_to_ds_valid (fs_to_ds_valid),
        .if_id_bus_out  (if_id_bus_out),
        .br_jmp_flag    (br_jmp_flag),
        .br_target      (br_target),
        .trap_flag      (trap_flag),
        .trap_target    (trap_target),
        .inst_sram_en   (inst_sram_en),
        .inst_sram_addr (inst_sram_addr),
        .inst_sram_rdata(inst_sram_rdata)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: word[i] = i
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a >> 2;
    endfunction

    // SRAM: data valid only in the cycle after a request
    always @(posedge clk) begin
        if (inst_sram_en) inst_sram_rdata <= mem_word(inst_sram_addr);
        else              inst_sram_rdata <= $urandom;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: sampled on every negedge
    logic        m_pf;
    logic        m_valid;
    logic [31:0] m_pc;

    always @(negedge clk) begin
        logic        redir;
        logic [31:0] nxt;
        logic        e_valid;
        logic        e_en;
        if (!rst_n) begin
            check("rst_valid", {63'd0, fs_to_ds_valid}, 64'd0);
            check("rst_bus", if_id_bus_out, 64'd0);
            check("rst_en", {63'd0, inst_sram_en}, 64'd0);
            m_pf    = 1'b0;
            m_valid = 1'b0;
            m_pc    = RESET_PC - 32'd4;
        end else begin
            redir   = trap_flag | br_jmp_flag;
            nxt     = trap_flag ? trap_target : (br_jmp_flag ? br_target : m_pc + 32'd4);
            e_valid = m_valid && !redir;
            e_en    = m_pf && (!m_valid || ds_allowin || redir);
            check("m_valid", {63'd0, fs_to_ds_valid}, {63'd0, e_valid});
            check("m_bus", if_id_bus_out, e_valid ? {mem_word(m_pc), m_pc} : 64'd0);
            check("m_en", {63'd0, inst_sram_en}, {63'd0, e_en});
            if (e_en) check("m_addr", {32'd0, inst_sram_addr}, {32'd0, nxt[31:2], 2'b00});
            if (e_en) begin
                m_valid = 1'b1;
                m_pc    = nxt;
            end
            m_pf = 1'b1;
        end
    end

    // Driver helpers
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cyc(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                              input logic en, input logic [31:0] addr);
        @(negedge clk);
        check("lit_valid", {63'd0, fs_to_ds_valid}, {63'd0, v});
        check("lit_bus", if_id_bus_out, v ? {inst, pc} : 64'd0);
        check("lit_en", {63'd0, inst_sram_en}, {63'd0, en});
        if (en) check("lit_addr", {32'd0, inst_sram_addr}, {32'd0, addr});
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        rst_n       = 1'b0;
        ds_allowin  = 1'b1;
        br_jmp_flag = 1'b0;
        br_target   = 32'd0;
        trap_flag   = 1'b0;
        trap_target = 32'd0;
        repeat (3) next_cycle();

        // Reset release; a redirect in the pf_valid=0 cycle is ignored
        rst_n       = 1'b1;
        br_jmp_flag = 1'b1;
        br_target   = 32'h300;
        expect_cyc(0, 0, 0, 0, 0);
        next_cycle();
        br_jmp_flag = 1'b0;
        expect_cyc(0, 0, 0, 1, 32'h0);
        expect_cyc(1, 32'd0, 32'h0, 1, 32'h4);
        expect_cyc(1, 32'd1, 32'h4, 1, 32'h8);

        // Decode stall for 3 cycles on pc 8
        next_cycle();
        ds_allowin = 1'b0;
        expect_cyc(1, 32'd2, 32'h8, 0, 0);
        expect_cyc(1, 32'd2, 32'h8, 0, 0);
        expect_cyc(1, 32'd2, 32'h8, 0, 0);
        next_cycle();
        ds_allowin = 1'b1;
        expect_cyc(1, 32'd2, 32'h8, 1, 32'hC);
        expect_cyc(1, 32'd3, 32'hC, 1, 32'h10);

        // Branch while pc 0x10 is valid
        next_cycle();
        br_jmp_flag = 1'b1;
        br_target   = 32'h100;
        expect_cyc(0, 0, 0, 1, 32'h100);
        next_cycle();
        br_jmp_flag = 1'b0;
        expect_cyc(1, 32'h40, 32'h100, 1, 32'h104);

        // Trap and branch together: trap wins
        next_cycle();
        trap_flag   = 1'b1;
        trap_target = 32'h200;
        br_jmp_flag = 1'b1;
        br_target   = 32'h100;
        expect_cyc(0, 0, 0, 1, 32'h200);
        next_cycle();
        trap_flag   = 1'b0;
        br_jmp_flag = 1'b0;
        expect_cyc(1, 32'h80, 32'h200, 1, 32'h204);

        // Redirect during a decode stall
        next_cycle();
        ds_allowin  = 1'b0;
        br_jmp_flag = 1'b1;
        br_target   = 32'h40;
        expect_cyc(0, 0, 0, 1, 32'h40);
        next_cycle();
        br_jmp_flag = 1'b0;
        expect_cyc(1, 32'h10, 32'h40, 0, 0);
        expect_cyc(1, 32'h10, 32'h40, 0, 0);
        next_cycle();
        ds_allowin = 1'b1;
        expect_cyc(1, 32'h10, 32'h40, 1, 32'h44);
        expect_cyc(1, 32'h11, 32'h44, 1, 32'h48);

        // Asynchronous reset mid-stream
        next_cycle();
        rst_n = 1'b0;
        #1;
        check("async_valid", {63'd0, fs_to_ds_valid}, 64'd0);
        check("async_bus", if_id_bus_out, 64'd0);
        check("async_en", {63'd0, inst_sram_en}, 64'd0);
        next_cycle();
        rst_n = 1'b1;
        expect_cyc(0, 0, 0, 0, 0);
        expect_cyc(0, 0, 0, 1, 32'h0);
        expect_cyc(1, 32'd0, 32'h0, 1, 32'h4);

        // Misaligned target keeps full pc, address aligned
        next_cycle();
        br_jmp_flag = 1'b1;
        br_target   = 32'h103;
        expect_cyc(0, 0, 0, 1, 32'h100);
        next_cycle();
        br_jmp_flag = 1'b0;
        expect_cyc(1, 32'h40, 32'h103, 1, 32'h104);

        // Wrap-around at top of address space
        next_cycle();
        br_jmp_flag = 1'b1;
        br_target   = 32'hFFFF_FFFC;
        expect_cyc(0, 0, 0, 1, 32'hFFFF_FFFC);
        next_cycle();
        br_jmp_flag = 1'b0;
        expect_cyc(1, 32'h3FFF_FFFF, 32'hFFFF_FFFC, 1, 32'h0);
        expect_cyc(1, 32'd0, 32'h0, 1, 32'h4);

        // Randomized phase
        for (int i = 0; i < 4000; i++) begin
            next_cycle();
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                br_jmp_flag = 1'b0;
                trap_flag   = 1'b0;
                repeat ($urandom_range(1, 2)) next_cycle();
                rst_n = 1'b1;
            end
            ds_allowin  = ($urandom_range(0, 9) < 7);
            br_jmp_flag = ($urandom_range(0, 9) == 0);
            trap_flag   = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 3))
                0:       br_target = 32'hFFFF_FFFC;
                1:       br_target = $urandom;
                default: br_target = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
            endcase
            trap_target = ($urandom_range(0, 3) == 0) ? $urandom
                        : {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
        end
        next_cycle();
        br_jmp_flag = 1'b0;
        trap_flag   = 1'b0;
        repeat (3) next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
